// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit and its FIFOs.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    // Fetch control states: RST while held in reset, RUN normally,
    // DRAIN while stale responses from before a redirect are still due.
    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Prefetch queue entry; the queue stores the same {pc, inst} order at any XLEN.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with occupancy count and flush; DEPTH must be a power of two.
module fifo_sync
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             push_i,
    input  logic [WIDTH-1:0]                 wdata_i,
    input  logic                             pop_i,
    output logic [WIDTH-1:0]                 rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointer/count update; flush empties the FIFO and wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited prefetch into an in-order queue,
// with redirect handling that discards responses still in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned   XLEN     = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned QW = 2 * XLEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   dcnt_q, dcnt_d;

    logic [CW-1:0]   qcnt;
    logic [CW-1:0]   ocnt;
    logic [QW-1:0]   q_head;
    logic [XLEN-1:0] inflight_pc;

    logic            credit_ok;
    logic            req;
    logic            grant;
    logic            drop;
    logic            q_push;
    logic            q_pop;
    logic            inst_valid;

    // Request credit, response routing and next-state computation.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        dcnt_d     = dcnt_q;

        credit_ok  = (SW'(qcnt) + SW'(ocnt)) < SW'(DEPTH);
        req        = (state_q != ST_RST) && !redirect_i && credit_ok;
        grant      = req && imem_gnt_i;
        // A response in a redirect cycle is stale too, so it is dropped.
        drop       = imem_rvalid_i && (redirect_i || (dcnt_q != '0));
        q_push     = imem_rvalid_i && !drop;
        inst_valid = (qcnt != '0);
        q_pop      = inst_valid && inst_ready_i;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~XLEN'(3);
            dcnt_d     = ocnt - CW'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (drop) begin
                dcnt_d = dcnt_q - CW'(1);
            end
        end

        if (state_q == ST_RST) begin
            state_d = ST_RUN;
        end else begin
            state_d = (dcnt_d != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RST;
            fetch_pc_q <= RESET_PC;
            dcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            dcnt_q     <= dcnt_d;
        end
    end

    // Addresses of granted requests, popped by every response (kept or dropped).
    fifo_sync #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_inflight (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (grant),
        .wdata_i (fetch_pc_q),
        .pop_i   (imem_rvalid_i),
        .rdata_o (inflight_pc),
        .count_o (ocnt)
    );

    // Prefetch queue toward decode; a redirect flushes it after any same-cycle pop.
    fifo_sync #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (q_push),
        .wdata_i ({inflight_pc, imem_rdata_i}),
        .pop_i   (q_pop),
        .rdata_o (q_head),
        .count_o (qcnt)
    );

    assign imem_req_o   = req;
    assign imem_addr_o  = fetch_pc_q;
    assign inst_valid_o = inst_valid;
    assign inst_o       = q_head[XLEN-1:0];
    assign inst_pc_o    = q_head[QW-1:XLEN];

    // The credit rule must keep the queue from ever receiving a response while full.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(q_push && (qcnt == CW'(DEPTH))));

    // Every response must match a granted request.
    a_resp_tracked: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rvalid_i && (ocnt == '0)));

endmodule
